// File: rtl/shift194_ctrl.sv
// shift194_ctrl: sequences an SN74LS194 through one parallel load followed by
// 0-4 shifts per accepted word, and exposes the outgoing serial bit stream.
module shift194_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_dir,
  input  logic             in_fill,
  input  logic [2:0]       in_len,
  output logic [1:0]       set,
  output logic             ds,
  output logic [3:0]       P,
  input  logic [3:0]       q,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned LEN_W = 3;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       data_r;
  logic             dir_r;
  logic             fill_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic             done_r;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  // Sequencer state, captured word fields, shift counter and completion count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      data_r   <= '0;
      dir_r    <= 1'b0;
      fill_r   <= 1'b0;
      len_r    <= '0;
      cnt      <= '0;
      done_r   <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_r <= in_data;
            dir_r  <= in_dir;
            fill_r <= in_fill;
            len_r  <= (in_len > LEN_MAX) ? LEN_MAX : in_len;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (len_r == '0) begin
            state    <= IDLE;
            done_r   <= 1'b1;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
          end else begin
            cnt   <= len_r;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state    <= IDLE;
            done_r   <= 1'b1;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the 194 mode and serial stream from state and captured fields.
  always_comb begin
    set          = 2'b00;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    in_ready     = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      LOAD: set = 2'b11;
      SHIFT: begin
        set          = dir_r ? 2'b01 : 2'b10;
        serial_valid = 1'b1;
        serial_out   = dir_r ? q[0] : q[3];
      end
      default: set = 2'b00;
    endcase
  end

  assign P    = data_r;
  assign ds   = fill_r;
  assign done = done_r;

endmodule

// File: tb/tb_shift194_ctrl.sv
// tb_shift194_ctrl: directed test of shift194_ctrl driving a behavioural 194.
module tb_shift194_ctrl;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       in_fill;
  logic [2:0] in_len;
  logic [1:0] set;
  logic       ds;
  logic [3:0] p_bus;
  logic [3:0] q;
  logic       serial_out;
  logic       serial_valid;
  logic       done;
  logic [7:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  shift194_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .in_fill(in_fill), .in_len(in_len),
    .set(set), .ds(ds), .P(p_bus), .q(q),
    .serial_out(serial_out), .serial_valid(serial_valid),
    .done(done), .xfer_cnt(xfer_cnt)
  );

  // Behavioural SN74LS194: clear, load, shift left (ds into q[0]), shift right (ds into q[3]).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= 4'b0000;
    else begin
      case (set)
        2'b11:   q <= p_bus;
        2'b10:   q <= {q[2:0], ds};
        2'b01:   q <= {ds, q[3:1]};
        default: q <= q;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and take it on the next edge; leaves the bench 1 time unit after that edge.
  task automatic send(input logic [3:0] d, input logic dir, input logic fill, input logic [2:0] len);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_fill  = fill;
    in_len   = len;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] bits;
    int         nshift;

    clr = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_fill = 1'b0; in_len = '0;
    #2 clr = 1'b1;
    #1;
    chk("rst_set", 8'(set), 8'h0);
    chk("rst_p", 8'(p_bus), 8'h0);
    chk("rst_ds", 8'(ds), 8'h0);
    chk("rst_sv", 8'(serial_valid), 8'h0);
    chk("rst_so", 8'(serial_out), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_cnt", xfer_cnt, 8'h0);
    chk("rst_ready", 8'(in_ready), 8'h1);
    step();
    clr = 1'b0;

    // Left shift 1011, len 4, fill 0
    send(4'b1011, 1'b0, 1'b0, 3'd4);
    chk("l_load_set", 8'(set), 8'h3);
    chk("l_load_p", 8'(p_bus), 8'hb);
    chk("l_load_ready", 8'(in_ready), 8'h0);
    step();
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk("l_set", 8'(set), 8'h2);
      chk("l_sv", 8'(serial_valid), 8'h1);
      chk("l_bit", 8'(serial_out), 8'(bits[3-i]));
      step();
    end
    chk("l_done", 8'(done), 8'h1);
    chk("l_q", 8'(q), 8'h0);
    chk("l_cnt", xfer_cnt, 8'd1);
    chk("l_idle_set", 8'(set), 8'h0);
    step();
    chk("l_done_pulse", 8'(done), 8'h0);

    // Right shift 1011, len 2, fill 1
    send(4'b1011, 1'b1, 1'b1, 3'd2);
    chk("r_load_set", 8'(set), 8'h3);
    step();
    chk("r_q0", 8'(q), 8'hb);
    chk("r_set0", 8'(set), 8'h1);
    chk("r_ds", 8'(ds), 8'h1);
    chk("r_bit0", 8'(serial_out), 8'h1);
    step();
    chk("r_q1", 8'(q), 8'hd);
    chk("r_set1", 8'(set), 8'h1);
    chk("r_bit1", 8'(serial_out), 8'h1);
    step();
    chk("r_q2", 8'(q), 8'he);
    chk("r_set_end", 8'(set), 8'h0);
    chk("r_done", 8'(done), 8'h1);
    chk("r_cnt", xfer_cnt, 8'd2);
    step();

    // Load only, len 0
    send(4'b0110, 1'b0, 1'b0, 3'd0);
    chk("z_load_set", 8'(set), 8'h3);
    chk("z_load_sv", 8'(serial_valid), 8'h0);
    step();
    chk("z_done", 8'(done), 8'h1);
    chk("z_q", 8'(q), 8'h6);
    chk("z_sv", 8'(serial_valid), 8'h0);
    chk("z_cnt", xfer_cnt, 8'd3);
    step();

    // len 7 clamps to 4 shifts
    send(4'b1011, 1'b0, 1'b0, 3'd7);
    step();
    nshift = 0;
    for (int i = 0; i < 10; i++) begin
      if (set == 2'b10) nshift++;
      if (done) break;
      step();
    end
    chk("c_shifts", 8'(nshift), 8'd4);
    chk("c_done", 8'(done), 8'h1);
    chk("c_cnt", xfer_cnt, 8'd4);
    step();

    // Back-to-back: A=1100 then B=0011, in_valid held
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b0; in_fill = 1'b0; in_len = 3'd4;
    step();
    in_data = 4'b0011;
    chk("b_a_load", 8'(set), 8'h3);
    step();
    bits = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      chk("b_a_bit", 8'(serial_out), 8'(bits[3-i]));
      step();
    end
    chk("b_a_done", 8'(done), 8'h1);
    chk("b_a_ready", 8'(in_ready), 8'h1);
    step();
    in_valid = 1'b0;
    chk("b_gap_set", 8'(set), 8'h3);
    chk("b_gap_sv", 8'(serial_valid), 8'h0);
    chk("b_b_p", 8'(p_bus), 8'h3);
    step();
    bits = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      chk("b_b_sv", 8'(serial_valid), 8'h1);
      chk("b_b_bit", 8'(serial_out), 8'(bits[3-i]));
      step();
    end
    chk("b_b_done", 8'(done), 8'h1);
    chk("b_cnt", xfer_cnt, 8'd6);
    step();

    // Abort with clr after the second shift of a len-4 word
    send(4'b1111, 1'b0, 1'b0, 3'd4);
    step();
    step();
    step();
    clr = 1'b1;
    #1;
    chk("a_set", 8'(set), 8'h0);
    chk("a_sv", 8'(serial_valid), 8'h0);
    chk("a_q", 8'(q), 8'h0);
    chk("a_done", 8'(done), 8'h0);
    chk("a_cnt", xfer_cnt, 8'd0);
    step();
    clr = 1'b0;
    step();
    chk("a_no_done", 8'(done), 8'h0);
    chk("a_cnt_hold", xfer_cnt, 8'd0);
    send(4'b1001, 1'b1, 1'b0, 3'd1);
    step();
    chk("a_next_bit", 8'(serial_out), 8'h1);
    step();
    chk("a_next_done", 8'(done), 8'h1);
    chk("a_next_q", 8'(q), 8'h4);
    chk("a_next_cnt", xfer_cnt, 8'd1);
    step();

    // Counter wrap: clear, then 256 len-0 words
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      send(4'b0101, 1'b0, 1'b0, 3'd0);
      step();
    end
    chk("w_255", xfer_cnt, 8'd255);
    send(4'b0101, 1'b0, 1'b0, 3'd0);
    step();
    chk("w_done", 8'(done), 8'h1);
    chk("w_wrap", xfer_cnt, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
